// File: rtl/score_collector.sv
// Collects scored beats from the last PE into a first-word-fall-through boundary FIFO
// and tracks the best H score seen, with the row and pass where it occurred.
module score_collector #(
    parameter int W     = 16,
    parameter int DEPTH = 256,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          validIn,
    input  logic          newLineIn,
    input  logic [1:0]    tIn,
    input  logic [W-1:0]  vIn,
    input  logic [W-1:0]  vIn_alpha,
    input  logic [W-1:0]  fIn,
    input  logic          pop,
    output logic          outValid,
    output logic          newLineOut,
    output logic [1:0]    tOut,
    output logic [W-1:0]  vOut,
    output logic [W-1:0]  vOut_alpha,
    output logic [W-1:0]  fOut,
    output logic          full,
    output logic          overflow,
    output logic [W-1:0]  maxScore,
    output logic [CW-1:0] maxRow,
    output logic [CW-1:0] maxPass
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 * W + 3;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;

    logic [CW-1:0]  row_q, row_d;
    logic [CW-1:0]  pass_q, pass_d;
    logic           seen_q, seen_d;
    logic [W-1:0]   max_score_q, max_score_d;
    logic [CW-1:0]  max_row_q, max_row_d;
    logic [CW-1:0]  max_pass_q, max_pass_d;

    logic           fifo_full;
    logic           fifo_nonempty;
    logic           do_pop;
    logic           do_push;
    logic [CW-1:0]  row_cur;
    logic [CW-1:0]  pass_cur;
    logic [EW-1:0]  head;

    assign fifo_full     = (count_q == FULL_CNT);
    assign fifo_nonempty = (count_q != '0);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop && fifo_nonempty && !clear;
    assign do_push = validIn && (!fifo_full || pop) && !clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (validIn && fifo_full && !pop) overflow_d = 1'b1;
        end
    end

    always_comb begin
        row_cur  = newLineIn ? '0 : ((&row_q) ? row_q : row_q + 1'b1);
        pass_cur = pass_q;
        if (newLineIn && seen_q && !(&pass_q)) pass_cur = pass_q + 1'b1;
    end

    always_comb begin
        row_d       = row_q;
        pass_d      = pass_q;
        seen_d      = seen_q;
        max_score_d = max_score_q;
        max_row_d   = max_row_q;
        max_pass_d  = max_pass_q;
        if (clear) begin
            row_d       = '0;
            pass_d      = '0;
            seen_d      = 1'b0;
            max_score_d = '0;
            max_row_d   = '0;
            max_pass_d  = '0;
        end else if (validIn) begin
            row_d  = row_cur;
            pass_d = pass_cur;
            seen_d = 1'b1;
            // Strict compare keeps the earliest position on ties.
            if (vIn > max_score_q) begin
                max_score_d = vIn;
                max_row_d   = row_cur;
                max_pass_d  = pass_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {newLineIn, tIn, vIn, vIn_alpha, fIn};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            row_q       <= '0;
            pass_q      <= '0;
            seen_q      <= 1'b0;
            max_score_q <= '0;
            max_row_q   <= '0;
            max_pass_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            row_q       <= row_d;
            pass_q      <= pass_d;
            seen_q      <= seen_d;
            max_score_q <= max_score_d;
            max_row_q   <= max_row_d;
            max_pass_q  <= max_pass_d;
        end
    end

    // Head fields read as zero when empty so nothing stale leaks out during reset.
    assign head = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    assign {newLineOut, tOut, vOut, vOut_alpha, fOut} = head;

    assign outValid = fifo_nonempty;
    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign maxScore = max_score_q;
    assign maxRow   = max_row_q;
    assign maxPass  = max_pass_q;

endmodule

// File: tb/tb_score_collector.sv
// Bench for score_collector: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_score_collector;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          validIn = 1'b0;
    logic          newLineIn = 1'b0;
    logic [1:0]    tIn = '0;
    logic [W-1:0]  vIn = '0;
    logic [W-1:0]  vIn_alpha = '0;
    logic [W-1:0]  fIn = '0;
    logic          pop = 1'b0;
    logic          outValid, newLineOut, full, overflow;
    logic [1:0]    tOut;
    logic [W-1:0]  vOut, vOut_alpha, fOut, maxScore;
    logic [CW-1:0] maxRow, maxPass;

    score_collector #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .validIn(validIn), .newLineIn(newLineIn), .tIn(tIn),
        .vIn(vIn), .vIn_alpha(vIn_alpha), .fIn(fIn), .pop(pop),
        .outValid(outValid), .newLineOut(newLineOut), .tOut(tOut),
        .vOut(vOut), .vOut_alpha(vOut_alpha), .fOut(fOut),
        .full(full), .overflow(overflow),
        .maxScore(maxScore), .maxRow(maxRow), .maxPass(maxPass)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordinary queue of entries plus tracker bookkeeping.
    typedef struct packed {
        logic         nl;
        logic [1:0]   t;
        logic [W-1:0] v;
        logic [W-1:0] va;
        logic [W-1:0] f;
    } entry_t;

    entry_t    m_q[$];
    bit        m_ovf = 0;
    bit        m_seen = 0;
    int        m_row = 0;
    int        m_pass = 0;
    int        m_max = 0;
    int        m_max_row = 0;
    int        m_max_pass = 0;
    localparam int SAT = (1 << CW) - 1;

    always @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            m_q.delete();
            m_ovf = 0; m_seen = 0; m_row = 0; m_pass = 0;
            m_max = 0; m_max_row = 0; m_max_pass = 0;
        end else begin
            bit was_full, can_pop, can_push;
            entry_t e;
            was_full = (m_q.size() == DEPTH);
            can_pop  = pop && (m_q.size() > 0);
            can_push = validIn && (!was_full || pop);
            if (validIn && was_full && !pop) m_ovf = 1;
            e = '{nl: newLineIn, t: tIn, v: vIn, va: vIn_alpha, f: fIn};
            if (can_pop) void'(m_q.pop_front());
            if (can_push) m_q.push_back(e);
            if (validIn) begin
                if (newLineIn) begin
                    m_row = 0;
                    if (m_seen && m_pass < SAT) m_pass++;
                end else if (m_row < SAT) begin
                    m_row++;
                end
                m_seen = 1;
                if (int'(vIn) > m_max) begin
                    m_max = int'(vIn); m_max_row = m_row; m_max_pass = m_pass;
                end
            end
        end
    end

    bit   log_en = 0;
    int   pop_log[$];

    always @(negedge clk) begin
        chk("outValid", outValid, m_q.size() != 0);
        chk("full", full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("maxScore", maxScore, m_max);
        chk("maxRow", maxRow, m_max_row);
        chk("maxPass", maxPass, m_max_pass);
        if (m_q.size() != 0) begin
            chk("newLineOut", newLineOut, m_q[0].nl);
            chk("tOut", tOut, m_q[0].t);
            chk("vOut", vOut, m_q[0].v);
            chk("vOut_alpha", vOut_alpha, m_q[0].va);
            chk("fOut", fOut, m_q[0].f);
        end
        if (log_en && rst && !clear && pop && outValid) pop_log.push_back(int'(vOut));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic nl, input int v, input logic p);
        validIn   = 1'b1;
        newLineIn = nl;
        vIn       = W'(v);
        tIn       = 2'(v);
        vIn_alpha = W'(v + 100);
        fIn       = W'(v + 200);
        pop       = p;
    endtask

    task automatic idle();
        validIn = 1'b0; newLineIn = 1'b0; pop = 1'b0; clear = 1'b0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        int nxt;
        bit done;
        int trk_v[7];
        bit trk_nl[7];

        repeat (2) cyc();
        chk("reset_outValid", outValid, 0);
        chk("reset_maxScore", maxScore, 0);
        rst = 1'b1;
        cyc();

        // First-word fall-through
        validIn = 1'b1; newLineIn = 1'b1; tIn = 2'd2; vIn = 16'd7; vIn_alpha = 16'd3; fIn = 16'd4;
        cyc();
        idle();
        chk("fwft_outValid", outValid, 1);
        chk("fwft_tOut", tOut, 2);
        chk("fwft_vOut", vOut, 7);
        chk("fwft_vOut_alpha", vOut_alpha, 3);
        chk("fwft_fOut", fOut, 4);
        chk("fwft_newLineOut", newLineOut, 1);
        pop = 1'b1;
        cyc();
        idle();
        chk("fwft_pop_outValid", outValid, 0);

        // Fill, overflow, push-through-pop while full
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            beat(1'b0, i, 1'b0);
            cyc();
        end
        chk("full_after4", full, 1);
        beat(1'b0, 5, 1'b0);
        cyc();
        chk("overflow_set", overflow, 1);
        chk("drop_head", vOut, 1);
        beat(1'b0, 6, 1'b1);
        cyc();
        idle();
        chk("full_stays", full, 1);
        chk("head_beat2", vOut, 2);

        // Async reset with a full FIFO and sticky overflow
        rst = 1'b0;
        #1;
        chk("rst_outValid", outValid, 0);
        chk("rst_maxScore", maxScore, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_full", full, 0);
        cyc();
        rst = 1'b1;
        cyc();

        // Wrap-around with random pop
        log_en = 1;
        nxt = 1;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            logic p;
            p = (m_q.size() > 0) && ((nxt > 10) || ($urandom_range(0, 1) == 1));
            if (nxt <= 10 && (m_q.size() < DEPTH || p)) begin
                beat(1'b0, nxt, p);
                nxt++;
            end else begin
                validIn = 1'b0;
                pop = p;
            end
            cyc();
            if (nxt > 10 && m_q.size() == 0) done = 1;
        end
        idle();
        log_en = 0;
        chk("wrap_done", done, 1);
        chk("wrap_count", pop_log.size(), 10);
        for (int i = 0; i < pop_log.size(); i++) chk("wrap_order", pop_log[i], i + 1);
        chk("wrap_overflow", overflow, 0);

        // Tracker: pass0 3,9,9,2 ; pass1 5,12,12
        do_clear();
        trk_v  = '{3, 9, 9, 2, 5, 12, 12};
        trk_nl = '{1, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            beat(trk_nl[i], trk_v[i], 1'b1);
            cyc();
        end
        idle();
        cyc();
        chk("trk_maxScore", maxScore, 12);
        chk("trk_maxRow", maxRow, 1);
        chk("trk_maxPass", maxPass, 1);

        // Clear colliding with push and pop
        beat(1'b0, 4, 1'b0);
        cyc();
        beat(1'b0, 5, 1'b0);
        cyc();
        beat(1'b1, 100, 1'b1);
        clear = 1'b1;
        cyc();
        idle();
        chk("clr_outValid", outValid, 0);
        chk("clr_maxScore", maxScore, 0);
        chk("clr_maxPass", maxPass, 0);
        beat(1'b1, 50, 1'b0);
        cyc();
        idle();
        cyc();
        chk("post_clr_maxScore", maxScore, 50);
        chk("post_clr_maxPass", maxPass, 0);
        chk("post_clr_maxRow", maxRow, 0);
        chk("post_clr_head", vOut, 50);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
